// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: shared op encodings, default latencies and FSM state type for the multiply/divide unit
package mdu_pkg;
   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mdu_if: E-stage request and HI/LO/busy response bundle of the multiply/divide unit
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output start, op, src_a, src_b, input busy, hi, lo);
   modport slave  (input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit_compute.sv
// mdu_compute: combinational {hi,lo} result for one op; divide by zero yields the hold value
module mdu_compute
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] hold,
   output logic [63:0] res
);
   logic signed [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] mag_a, mag_b, q_s, r_s;
   // signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a trap
   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'b0, a} * {32'b0, b};
      mag_a  = a[31] ? -a : a;
      mag_b  = b[31] ? -b : b;
      q_s    = (b == 32'd0) ? 32'd0 : mag_a / mag_b;
      r_s    = (b == 32'd0) ? 32'd0 : mag_a % mag_b;
      res    = hold;
      case (op)
         MDU_MULT:  res = prod_s;
         MDU_MULTU: res = prod_u;
         MDU_DIV:   res = (b == 32'd0) ? hold : {(a[31] ? -r_s : r_s), ((a[31] ^ b[31]) ? -q_s : q_s)};
         MDU_DIVU:  res = (b == 32'd0) ? hold : {a % b, a / b};
         default:   res = hold;
      endcase
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide with architectural HI/LO and a registered busy flag
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic clk,
   input logic rst_n,
   mdu_if.slave bus
);
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic [63:0] res;

   mdu_compute u_compute (
      .op   (bus.op),
      .a    (bus.src_a),
      .b    (bus.src_b),
      .hold ({hi_q, lo_q}),
      .res  (res)
   );

   assign bus.busy = (state_q == BUSY);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // accept requests in IDLE, count down in BUSY and commit the pending result on the last edge
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      if (state_q == IDLE) begin
         if (bus.start) begin
            case (bus.op)
               MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                  res_hi_d = res[63:32];
                  res_lo_d = res[31:0];
                  cnt_d    = (bus.op == MDU_MULT || bus.op == MDU_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                  state_d  = BUSY;
               end
               MDU_MTHI: hi_d = bus.src_a;
               MDU_MTLO: lo_d = bus.src_a;
               default: ;
            endcase
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            hi_d    = res_hi_q;
            lo_d    = res_lo_q;
            state_d = IDLE;
         end
      end
   end

   // state, counter, pending result and HI/LO registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit latency, results, MTHI/MTLO and reset
module tb_mult_div_unit;
   import mdu_pkg::*;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   mdu_if bus();

   mult_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_busy(input int n, input logic [31:0] old_hi, input logic [31:0] old_lo);
      for (int k = 0; k < n; k++) begin
         chk("busy_window", 32'(bus.busy), 32'd1);
         chk("busy_hi_old", bus.hi, old_hi);
         chk("busy_lo_old", bus.lo, old_lo);
         bus.src_a = $urandom;
         bus.src_b = $urandom;
         tick();
      end
   endtask

   task automatic chk_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_hi"}, bus.hi, exp_hi);
      chk({tag, "_lo"}, bus.lo, exp_lo);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.op = MDU_MULT;
      bus.src_a = '0;
      bus.src_b = '0;
      tick();
      tick();
      chk_done("reset", 32'h0, 32'h0);
      rst_n = 1'b1;
      issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
      run_busy(5, 32'h0, 32'h0);
      chk_done("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA);
      issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
      run_busy(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      chk_done("multu", 32'h1, 32'hFFFFFFFE);
      issue(MDU_DIVU, 32'd7, 32'd2);
      run_busy(10, 32'h1, 32'hFFFFFFFE);
      chk_done("divu_b2b", 32'h1, 32'h3);
      issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
      run_busy(10, 32'h1, 32'h3);
      chk_done("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(MDU_DIV, 32'd5, 32'd0);
      run_busy(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk_done("div_zero", 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(MDU_DIVU, 32'd9, 32'd0);
      run_busy(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk_done("divu_zero", 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_busy(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk_done("div_ovf", 32'h0, 32'h80000000);
      issue(MDU_MTHI, 32'h12345678, 32'h0);
      chk_done("mthi", 32'h12345678, 32'h80000000);
      tick();
      chk("mthi_busy_later", 32'(bus.busy), 32'd0);
      issue(MDU_MTLO, 32'hCAFEF00D, 32'h0);
      chk_done("mtlo", 32'h12345678, 32'hCAFEF00D);
      issue(3'd6, 32'h11111111, 32'h2);
      chk_done("rsv6", 32'h12345678, 32'hCAFEF00D);
      issue(3'd7, 32'h22222222, 32'h3);
      chk_done("rsv7", 32'h12345678, 32'hCAFEF00D);
      issue(MDU_MULT, 32'd6, 32'd7);
      chk("mtlo_busy_pre", 32'(bus.busy), 32'd1);
      issue(MDU_MTLO, 32'hDEADBEEF, 32'h0);
      run_busy(4, 32'h12345678, 32'hCAFEF00D);
      chk_done("mtlo_ignored", 32'h0, 32'd42);
      tick();
      chk_done("mtlo_ignored_later", 32'h0, 32'd42);
      issue(MDU_MULT, 32'd100000, 32'hFFFFFFFD);
      run_busy(5, 32'h0, 32'd42);
      chk_done("operand_hold", 32'hFFFFFFFF, 32'hFFFB6C20);
      issue(MDU_MULT, 32'd3, 32'd4);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk_done("reset_busy", 32'h0, 32'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_done("reset_no_commit", 32'h0, 32'h0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide responder for the P6 pipeline execute stage. Accepts a one-cycle start request from the E stage carrying operation code and forwarded rs/rt operands. Holds a multi-cycle busy window, then commits the result to architectural HI/LO registers. Its busy output and current HI/LO values feed the hazard unit and the mfhi/mflo result path.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request valid this cycle (E-stage instruction is an MDU op)
- op  in  3  operation code (package constants)
- src_a  in  32  forwarded rs value
- src_b  in  32  forwarded rt value
- busy  out  1  multi-cycle operation in progress
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, BUSY. Down-counter cnt (4 bits, sized for max(MULT_CYCLES, DIV_CYCLES)). Pending result regs res_hi and res_lo.
- IDLE, start=1:
  - MULT: {res_hi,res_lo} = signed 64-bit product; cnt=MULT_CYCLES; go BUSY.
  - MULTU: same as MULT, unsigned product.
  - DIV: res_lo = quotient truncated toward zero; res_hi = remainder with sign of dividend; cnt=DIV_CYCLES; go BUSY.
  - DIVU: same as DIV, unsigned.
  - MTHI: hi = src_a at this edge; stay IDLE.
  - MTLO: lo = src_a at this edge; stay IDLE.
  - Reserved codes 6/7: no effect.
- BUSY: cnt decrements each edge. On the edge where cnt==1, hi=res_hi, lo=res_lo, go IDLE.
- start while BUSY: ignored entirely, including MTHI/MTLO. The hazard unit must stall these ops.
- Divide by zero (src_b==0, DIV or DIVU): full busy window runs; HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- HI/LO never show partial results; old values remain readable throughout BUSY.
- Operands are sampled only on the start edge; later changes to src_a/src_b have no effect.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, busy=0, hi=0, lo=0, res_hi=0, res_lo=0. Reset during BUSY aborts the operation; no commit.
- busy is registered and equals (state==BUSY).
- start sampled high at the end of cycle 0:
  - busy=1 in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO take new values and busy=0 in cycle N+1.
- A new start may be accepted in cycle N+1 (back-to-back). Its first busy cycle is N+2.
- MTHI/MTLO: new value visible in the cycle after start; busy never asserts.

## Structure
- Shared package mdu_pkg holds:
  - op encodings: MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5
  - default cycle constants, also used by the hazard unit's stall logic
- One sub-module: mdu_compute, combinational. Produces 64-bit {hi,lo} for a given op/a/b, including div-by-zero and overflow rules.
- Top module holds the FSM, counter and HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 → busy high cycles 1–5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU a=0xFFFFFFFF, b=2, then DIVU 7/2 issued in cycle 6 → after first: hi=1, lo=0xFFFFFFFE. Second: busy cycles 7–16; cycle 17: lo=3, hi=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → after 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV by 0 → HI/LO unchanged.
- MTHI 0x12345678 while IDLE → hi=0x12345678 next cycle, busy never high. MTLO issued during BUSY → lo unchanged, committed MULT result intact.
- rst_n=0 in cycle 3 of a MULT → next cycle busy=0, hi=lo=0; no commit afterward.
- src_a/src_b toggled every cycle during BUSY → committed result matches the operands present on the start edge.
